// File: rtl/rf_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rf_arb_pkg
// Description : Shared types and defaults for the register-file write
//               arbiter: width defaults, arbitration mode encoding and the
//               writeback request record.
// Revision    : 1.0 - initial release
// ============================================================================
package rf_arb_pkg;

    localparam int c_DEF_A_WIDTH = 5;
    localparam int c_DEF_D_WIDTH = 32;

    // Arbitration priority applied when both requesters are valid
    typedef enum logic [0:0] {
        PRIO_LSU = 1'b0,
        PRIO_ALU = 1'b1
    } arb_mode_e;

    // One writeback request at the default widths
    typedef struct packed {
        logic [c_DEF_A_WIDTH-1:0] rd;
        logic [c_DEF_D_WIDTH-1:0] data;
    } wb_req_t;

endpackage
`default_nettype wire

// File: rtl/rf_arb_starve_ctr.sv
`default_nettype none
// ============================================================================
// Module      : rf_arb_starve_ctr
// Description : Counts consecutive conflicts lost by the ALU and flips the
//               arbiter to ALU priority once it has lost STARVE_MAX in a row.
//               Any ALU writeback returns the arbiter to LSU priority.
// Revision    : 1.0 - initial release
// ============================================================================
module rf_arb_starve_ctr
    import rf_arb_pkg::*;
#(
    parameter int STARVE_MAX = 3
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      i_alu_valid,
    input  logic      i_alu_xfer,
    input  logic      i_lsu_conflict_win,
    output arb_mode_e o_mode
);

    // Counter value seen on the loss that completes the starvation run
    localparam logic [3:0] c_LAST_LOSS = 4'(STARVE_MAX - 1);

    arb_mode_e  r_mode;
    logic [3:0] r_starve_cnt;

    // Starvation counter and mode FSM, both cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mode       <= PRIO_LSU;
            r_starve_cnt <= 4'd0;
        end else begin
            if (i_alu_xfer || !i_alu_valid) begin
                r_starve_cnt <= 4'd0;
            end else if (i_lsu_conflict_win) begin
                r_starve_cnt <= r_starve_cnt + 4'd1;
            end

            case (r_mode)
                PRIO_LSU: begin
                    if (i_lsu_conflict_win && (r_starve_cnt == c_LAST_LOSS)) begin
                        r_mode <= PRIO_ALU;
                    end
                end
                PRIO_ALU: begin
                    if (i_alu_xfer) begin
                        r_mode <= PRIO_LSU;
                    end
                end
                default: r_mode <= PRIO_LSU;
            endcase
        end
    end

    assign o_mode = r_mode;

endmodule
`default_nettype wire

// File: rtl/rf_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rf_write_arbiter
// Description : Arbitrates ALU and load-return writebacks onto the single
//               register-file write port with one cycle of latency. LSU wins
//               conflicts by default; with RF_ARB_FAIR_EN defined a starvation
//               counter hands priority to the ALU after STARVE_MAX lost
//               conflicts in a row.
//               Build option: RF_ARB_FAIR_EN (undefined -> fixed LSU priority)
// Revision    : 1.0 - initial release
// ============================================================================
module rf_write_arbiter
    import rf_arb_pkg::*;
#(
    parameter int A_WIDTH    = c_DEF_A_WIDTH,
    parameter int D_WIDTH    = c_DEF_D_WIDTH,
    parameter int STARVE_MAX = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               alu_valid,
    output logic               alu_ready,
    input  logic [A_WIDTH-1:0] alu_rd,
    input  logic [D_WIDTH-1:0] alu_data,
    input  logic               lsu_valid,
    output logic               lsu_ready,
    input  logic [A_WIDTH-1:0] lsu_rd,
    input  logic [D_WIDTH-1:0] lsu_data,
    output logic               we3,
    output logic [A_WIDTH-1:0] ad3,
    output logic [D_WIDTH-1:0] wd3,
    output logic               conflict
);

    // The counter is 4 bits wide, so the threshold must fit in 1..15
    if ((STARVE_MAX < 1) || (STARVE_MAX > 15)) begin : g_starve_max_range
        $error("rf_write_arbiter: STARVE_MAX must lie in 1..15");
    end

    arb_mode_e          w_mode;
    logic               w_both;
    logic               w_alu_xfer;
    logic               w_lsu_xfer;
    logic               w_write;
    logic [A_WIDTH-1:0] w_sel_rd;
    logic [D_WIDTH-1:0] w_sel_data;

    logic               r_we3;
    logic [A_WIDTH-1:0] r_ad3;
    logic [D_WIDTH-1:0] r_wd3;
    logic               r_conflict;

    assign w_both = alu_valid && lsu_valid;

`ifdef RF_ARB_FAIR_EN
    rf_arb_starve_ctr #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve_ctr (
        .clk                (clk),
        .rst                (rst),
        .i_alu_valid        (alu_valid),
        .i_alu_xfer         (w_alu_xfer),
        .i_lsu_conflict_win (w_both && (w_mode == PRIO_LSU)),
        .o_mode             (w_mode)
    );
`else
    assign w_mode = PRIO_LSU;
`endif

    // Readies depend only on the valids and the mode, never on rd/data
    assign alu_ready  = !w_both || (w_mode == PRIO_ALU);
    assign lsu_ready  = !w_both || (w_mode == PRIO_LSU);
    assign w_alu_xfer = alu_valid && alu_ready;
    assign w_lsu_xfer = lsu_valid && lsu_ready;

    // At most one transfer per cycle, so a plain mux picks the winner
    assign w_sel_rd   = w_lsu_xfer ? lsu_rd   : alu_rd;
    assign w_sel_data = w_lsu_xfer ? lsu_data : alu_data;

    // Writes to r0 complete the handshake but never reach the register file
    assign w_write = (w_alu_xfer || w_lsu_xfer) && (w_sel_rd != '0);

    // Registered write port and conflict flag; address/data hold when idle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_we3      <= 1'b0;
            r_ad3      <= '0;
            r_wd3      <= '0;
            r_conflict <= 1'b0;
        end else begin
            r_we3      <= w_write;
            r_conflict <= w_both;
            if (w_write) begin
                r_ad3 <= w_sel_rd;
                r_wd3 <= w_sel_data;
            end
        end
    end

    assign we3      = r_we3;
    assign ad3      = r_ad3;
    assign wd3      = r_wd3;
    assign conflict = r_conflict;

endmodule
`default_nettype wire

// File: tb/tb_rf_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_rf_write_arbiter
// Description : Self-checking bench for rf_write_arbiter: directed scenarios
//               followed by random traffic against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rf_write_arbiter;
    import rf_arb_pkg::*;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int SM = 3;
`ifdef RF_ARB_FAIR_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          alu_valid;
    logic          alu_ready;
    logic [AW-1:0] alu_rd;
    logic [DW-1:0] alu_data;
    logic          lsu_valid;
    logic          lsu_ready;
    logic [AW-1:0] lsu_rd;
    logic [DW-1:0] lsu_data;
    logic          we3;
    logic [AW-1:0] ad3;
    logic [DW-1:0] wd3;
    logic          conflict;

    rf_write_arbiter #(
        .A_WIDTH    (AW),
        .D_WIDTH    (DW),
        .STARVE_MAX (SM)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .alu_valid (alu_valid),
        .alu_ready (alu_ready),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .lsu_valid (lsu_valid),
        .lsu_ready (lsu_ready),
        .lsu_rd    (lsu_rd),
        .lsu_data  (lsu_data),
        .we3       (we3),
        .ad3       (ad3),
        .wd3       (wd3),
        .conflict  (conflict)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Behavioural reference state
    logic          m_we;
    logic [AW-1:0] m_ad;
    logic [DW-1:0] m_wd;
    logic          m_conf;
    int            m_losses;
    bit            m_alu_prio;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_we       = 1'b0;
        m_ad       = '0;
        m_wd       = '0;
        m_conf     = 1'b0;
        m_losses   = 0;
        m_alu_prio = 1'b0;
    endtask

    // One clock cycle: drive at posedge+1, check readies, check outputs after the edge
    task automatic step(input bit av, input logic [AW-1:0] ard, input logic [DW-1:0] adat,
                        input bit lv, input logic [AW-1:0] lrd, input logic [DW-1:0] ldat);
        bit      both, alu_wins, e_ar, e_lr, ax, lx;
        wb_req_t acc;
        alu_valid = av;  alu_rd = ard;  alu_data = adat;
        lsu_valid = lv;  lsu_rd = lrd;  lsu_data = ldat;
        both     = av && lv;
        alu_wins = FAIR && both && m_alu_prio;
        e_ar     = !both || alu_wins;
        e_lr     = !both || !alu_wins;
        ax       = av && e_ar;
        lx       = lv && e_lr;
        #2;
        check("alu_ready", alu_ready, e_ar);
        check("lsu_ready", lsu_ready, e_lr);
        m_conf = both;
        m_we   = 1'b0;
        if (ax || lx) begin
            acc.rd   = lx ? lrd : ard;
            acc.data = lx ? ldat : adat;
            if (acc.rd != '0) begin
                m_we = 1'b1;
                m_ad = acc.rd;
                m_wd = acc.data;
            end
        end
        if (FAIR) begin
            if (ax || !av) m_losses = 0;
            else if (both) m_losses++;
            if (ax) m_alu_prio = 1'b0;
            else if (m_losses >= SM) m_alu_prio = 1'b1;
        end
        @(posedge clk);
        #1;
        check("we3", we3, m_we);
        check("ad3", ad3, m_ad);
        check("wd3", wd3, m_wd);
        check("conflict", conflict, m_conf);
    endtask

    initial begin
        logic [5:0] alu_pat;
        rst = 1'b1;
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
        model_reset();

        // Reset state is visible before any clock edge
        #2;
        check("rst_we3", we3, 1'b0);
        check("rst_ad3", ad3, '0);
        check("rst_wd3", wd3, '0);
        check("rst_conflict", conflict, 1'b0);
        check("rst_alu_ready", alu_ready, 1'b1);
        check("rst_lsu_ready", lsu_ready, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Leaving reset alone causes no write
        step(0, 0, 0, 0, 0, 0);

        // Single ALU writeback then idle
        step(1, 5'd5, 32'h1234_5678, 0, 0, 0);
        check("alu_only_ad3", ad3, 5'd5);
        step(0, 0, 0, 0, 0, 0);

        // Conflict: LSU first, ALU the cycle after
        step(1, 5'd4, 32'hBB, 1, 5'd3, 32'hAA);
        check("conflict_lsu_ad3", ad3, 5'd3);
        step(1, 5'd4, 32'hBB, 0, 0, 0);
        check("conflict_alu_ad3", ad3, 5'd4);

        // Six cycles of sustained conflict
        alu_pat = FAIR ? 6'b001000 : 6'b000000;
        for (int i = 0; i < 6; i++) begin
            step(1, 5'd4, 32'hBB, 1, 5'(10 + i), 32'hC000_0000 + 32'(i));
            check("grant_seq_ad3", ad3, alu_pat[i] ? 5'd4 : 5'(10 + i));
        end
        step(0, 0, 0, 0, 0, 0);

        // LSU write to r0: handshake completes, port stays quiet
        step(0, 0, 0, 1, 5'd0, 32'hFFFF_FFFF);
        check("r0_we3", we3, 1'b0);

        // Reset pulsed mid-cycle after a write clears outputs at once
        step(1, 5'd9, 32'hDEAD_BEEF, 0, 0, 0);
        alu_valid = 1'b0;
        #2; rst = 1'b1;
        #1;
        check("midrst_we3", we3, 1'b0);
        check("midrst_ad3", ad3, '0);
        check("midrst_wd3", wd3, '0);
        #1; rst = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        check("postrst_we3", we3, 1'b0);

        // A request present while reset is asserted is dropped
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h7777_7777;
        lsu_valid = 1'b1; lsu_rd = 5'd8; lsu_data = 32'h8888_8888;
        #2; rst = 1'b1;
        @(posedge clk);
        #1;
        check("droprst_we3", we3, 1'b0);
        check("droprst_ad3", ad3, '0);
        check("droprst_conflict", conflict, 1'b0);
        rst = 1'b0;
        model_reset();
        step(0, 0, 0, 0, 0, 0);

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            step($urandom_range(0, 3) != 0,
                 ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom),
                 $urandom,
                 $urandom_range(0, 3) != 0,
                 ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom),
                 $urandom);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
